score_keeper: RTL and testbench

// - Producer side of the score/game_over interface consumed by the on-screen score printer.
// - Counts points from game events and keeps a session high score.
// - Runs a 3-state game-phase FSM and drives game_over.
// - Also outputs the score as 4 BCD digits, so the display path can use them without dividers.

---
 rtl/score_keeper_pkg.sv | 34 +++
 rtl/score_keeper_bcd_digit_add.sv | 24 ++
 rtl/score_keeper.sv | 109 ++++++++++
 tb/tb_score_keeper.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types, constants and helper functions for the score keeper.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int ASCII_DIGIT_BASE = 48;

    // Number of bits needed to hold values 0..n-1.
    function automatic int logb2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((n - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    // Highest reachable score: one point per cell, capped at four decimal digits.
    function automatic int max_score(input int h, input int v);
        return ((h * v - 1) < 9999) ? (h * v - 1) : 9999;
    endfunction

    // Binary value (0..9999) to four packed BCD digits.
    function automatic logic [15:0] to_bcd(input int value);
        return {4'(value / 1000 % 10), 4'(value / 100 % 10),
                4'(value / 10 % 10), 4'(value % 10)};
    endfunction

    localparam int MAX_SCORE = max_score(32, 32);

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// One decimal digit of the BCD score adder; chained through cin/cout.
module bcd_digit_add (
    input  logic [3:0] digit,
    input  logic [3:0] addend,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    // Binary add, then fold anything above 9 back into the 0..9 range with a carry out.
    always_comb begin
        raw = {1'b0, digit} + {1'b0, addend} + {4'b0, cin};
        if (raw > 5'd9) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-phase FSM, saturating score counter with BCD mirror, and session high score.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int H      = 32,
    parameter int V      = 32,
    parameter int POINTS = 1,
    localparam int SB    = logb2(H * V)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_game,
    input  logic          eat,
    input  logic          collide,
    output logic [SB-1:0] score,
    output logic [15:0]   score_bcd,
    output logic [SB-1:0] high_score,
    output logic          game_over,
    output logic          playing,
    output logic          score_tick
);

    localparam int              MAX     = max_score(H, V);
    localparam logic [SB-1:0]   MAX_S   = SB'(MAX);
    localparam logic [SB+3:0]   MAX_W   = (SB + 4)'(MAX);
    localparam logic [15:0]     MAX_BCD = to_bcd(MAX);

    game_state_t   state, next_state;
    logic          start;
    logic [SB+3:0] sum;
    logic          at_max;
    logic [SB-1:0] next_score;
    logic [15:0]   next_bcd;
    logic [15:0]   bcd_sum;
    logic [4:0]    carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_add u_digit (
            .digit (score_bcd[4*i +: 4]),
            .addend(i == 0 ? 4'(POINTS) : 4'd0),
            .cin   (carry[i]),
            .sum   (bcd_sum[4*i +: 4]),
            .cout  (carry[i+1])
        );
    end

    // Game phase register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next phase: collide ends a game, new_game (re)starts one; collide beats new_game only in PLAY.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: if (new_game) begin
                next_state = PLAY;
                start      = 1'b1;
            end
            PLAY: if (collide) begin
                next_state = OVER;
            end else if (new_game) begin
                start = 1'b1;
            end
            OVER: if (new_game) begin
                next_state = PLAY;
                start      = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Candidate incremented score, clamped to the maximum in both binary and BCD form.
    always_comb begin
        sum        = {4'b0, score} + (SB + 4)'(POINTS);
        at_max     = (sum >= MAX_W) || carry[4];
        next_score = at_max ? MAX_S : sum[SB-1:0];
        next_bcd   = at_max ? MAX_BCD : bcd_sum;
    end

    // Score, tick strobe and high score; the high score latches once the game is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            score      <= '0;
            score_bcd  <= '0;
            high_score <= '0;
            score_tick <= 1'b0;
        end else begin
            score_tick <= 1'b0;
            if (start) begin
                score     <= '0;
                score_bcd <= '0;
            end else if (state == PLAY && eat && score != MAX_S) begin
                score      <= next_score;
                score_bcd  <= next_bcd;
                score_tick <= 1'b1;
            end
            if (state == OVER && score > high_score) high_score <= score;
        end
    end

    assign game_over = (state == OVER);
    assign playing   = (state == PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with the default 32x32 board.
module tb_score_keeper;

    localparam int SB = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          new_game = 1'b0;
    logic          eat = 1'b0;
    logic          collide = 1'b0;
    logic [SB-1:0] score;
    logic [15:0]   score_bcd;
    logic [SB-1:0] high_score;
    logic          game_over;
    logic          playing;
    logic          score_tick;

    int total = 0;
    int bad   = 0;

    score_keeper #(.H(32), .V(32), .POINTS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .new_game  (new_game),
        .eat       (eat),
        .collide   (collide),
        .score     (score),
        .score_bcd (score_bcd),
        .high_score(high_score),
        .game_over (game_over),
        .playing   (playing),
        .score_tick(score_tick)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs from the falling edge, then return 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic ng, input logic e, input logic c);
        @(negedge clk);
        rst      = r;
        new_game = ng;
        eat      = e;
        collide  = c;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        new_game = 1'b0;
        eat      = 1'b0;
        collide  = 1'b0;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0);
        total++;
        if ({score, score_bcd, high_score, game_over, playing, score_tick} !== '0) begin
            bad++;
            $display("[TB] FAIL reset: got score=%0d bcd=%h high=%0d go=%b play=%b tick=%b, want all 0",
                     score, score_bcd, high_score, game_over, playing, score_tick);
        end
    endtask

    task automatic test_idle_ignored;
        drive(0, 0, 1, 0);
        total++;
        if (score !== 10'd0 || score_tick !== 1'b0 || playing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_eat: got score=%0d tick=%b play=%b, want 0 0 0", score, score_tick, playing);
        end
        drive(0, 0, 0, 1);
        total++;
        if (game_over !== 1'b0 || playing !== 1'b0 || score !== 10'd0) begin
            bad++;
            $display("[TB] FAIL idle_collide: got go=%b play=%b score=%0d, want 0 0 0", game_over, playing, score);
        end
    endtask

    task automatic test_count12;
        int ticks = 0;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 0);
            if (score_tick === 1'b1) ticks++;
        end
        total++;
        if (score !== 10'd12 || score_bcd !== 16'h0012) begin
            bad++;
            $display("[TB] FAIL count12: got score=%0d bcd=%h, want 12 0012", score, score_bcd);
        end
        total++;
        if (ticks != 12 || playing !== 1'b1) begin
            bad++;
            $display("[TB] FAIL count12_ticks: got ticks=%0d play=%b, want 12 1", ticks, playing);
        end
        drive(0, 0, 0, 0);
        total++;
        if (score_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tick_width: got tick=%b, want 0", score_tick);
        end
    endtask

    task automatic test_bcd_carry;
        for (int i = 0; i < 87; i++) drive(0, 0, 1, 0);
        total++;
        if (score !== 10'd99 || score_bcd !== 16'h0099) begin
            bad++;
            $display("[TB] FAIL at99: got score=%0d bcd=%h, want 99 0099", score, score_bcd);
        end
        drive(0, 0, 1, 0);
        total++;
        if (score !== 10'd100 || score_bcd !== 16'h0100 || score_tick !== 1'b1) begin
            bad++;
            $display("[TB] FAIL carry100: got score=%0d bcd=%h tick=%b, want 100 0100 1", score, score_bcd, score_tick);
        end
    endtask

    task automatic test_eat_collide;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
        drive(0, 0, 1, 1);
        total++;
        if (score !== 10'd6 || game_over !== 1'b1 || playing !== 1'b0 || high_score !== 10'd0) begin
            bad++;
            $display("[TB] FAIL eat_collide: got score=%0d go=%b play=%b high=%0d, want 6 1 0 0",
                     score, game_over, playing, high_score);
        end
        drive(0, 0, 0, 0);
        total++;
        if (high_score !== 10'd6) begin
            bad++;
            $display("[TB] FAIL high_lag: got high=%0d, want 6", high_score);
        end
    endtask

    task automatic test_restart_from_over;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        total++;
        if (score !== 10'd3 || game_over !== 1'b1 || high_score !== 10'd6) begin
            bad++;
            $display("[TB] FAIL over3: got score=%0d go=%b high=%0d, want 3 1 6", score, game_over, high_score);
        end
        drive(0, 1, 0, 0);
        total++;
        if (score !== 10'd0 || score_bcd !== 16'h0000 || game_over !== 1'b0 || playing !== 1'b1 || high_score !== 10'd6) begin
            bad++;
            $display("[TB] FAIL restart: got score=%0d bcd=%h go=%b play=%b high=%0d, want 0 0000 0 1 6",
                     score, score_bcd, game_over, playing, high_score);
        end
    endtask

    task automatic test_new_game_collide;
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        total++;
        if (score !== 10'd0 || playing !== 1'b1 || high_score !== 10'd6) begin
            bad++;
            $display("[TB] FAIL play_restart: got score=%0d play=%b high=%0d, want 0 1 6", score, playing, high_score);
        end
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 1);
        total++;
        if (game_over !== 1'b1 || score !== 10'd1) begin
            bad++;
            $display("[TB] FAIL play_collide_wins: got go=%b score=%0d, want 1 1", game_over, score);
        end
        drive(0, 1, 0, 1);
        total++;
        if (playing !== 1'b1 || game_over !== 1'b0 || score !== 10'd0) begin
            bad++;
            $display("[TB] FAIL over_newgame_wins: got play=%b go=%b score=%0d, want 1 0 0", playing, game_over, score);
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 1023; i++) drive(0, 0, 1, 0);
        total++;
        if (score !== 10'd1023 || score_bcd !== 16'h1023) begin
            bad++;
            $display("[TB] FAIL at_max: got score=%0d bcd=%h, want 1023 1023", score, score_bcd);
        end
        drive(0, 0, 1, 0);
        total++;
        if (score !== 10'd1023 || score_bcd !== 16'h1023 || score_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL saturate: got score=%0d bcd=%h tick=%b, want 1023 1023 0", score, score_bcd, score_tick);
        end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        total++;
        if (high_score !== 10'd1023) begin
            bad++;
            $display("[TB] FAIL high_max: got high=%0d, want 1023", high_score);
        end
    endtask

    task automatic test_rst_mid;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        drive(1, 0, 1, 0);
        total++;
        if ({score, score_bcd, high_score, game_over, playing, score_tick} !== '0) begin
            bad++;
            $display("[TB] FAIL rst_mid: got score=%0d bcd=%h high=%0d go=%b play=%b tick=%b, want all 0",
                     score, score_bcd, high_score, game_over, playing, score_tick);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_idle_ignored();
        test_count12();
        test_bcd_carry();
        test_eat_collide();
        test_restart_from_over();
        test_new_game_collide();
        test_saturate();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
